// File: rtl/fake_netfpga_sram.sv
// ---------------------------------------------------------------------------
// fake_netfpga_sram
//
// Behavioural stand-in for NetFPGA external SRAM port 0. It is used in
// system-level benches next to the traffic_classifier datapath in place of
// the real SRAM controller. Each cycle it services at most one request,
// either a read or a write. When both requesters ask in the same cycle, the
// port alternates between them. Read data comes back RD_LATENCY cycles after
// acceptance, qualified by rd_0_vld.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   rd_0_req   read request, held until acked
//   rd_0_addr  read word address
//   rd_0_ack   read accepted this cycle (combinational)
//   rd_0_data  read data, zero whenever rd_0_vld is low
//   rd_0_vld   rd_0_data valid this cycle
//   wr_0_req   write request, held until acked
//   wr_0_addr  write word address
//   wr_0_data  write data
//   wr_0_ack   write accepted this cycle (combinational)
//
// MEM_ADDR_BITS must not exceed ADDR_WIDTH. Upper address bits are ignored,
// so addresses alias onto the same storage. RD_LATENCY must be at least 1.
// ---------------------------------------------------------------------------
module fake_netfpga_sram #(
    parameter int ADDR_WIDTH    = 19,
    parameter int DATA_WIDTH    = 72,
    parameter int MEM_ADDR_BITS = 19,
    parameter int RD_LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_0_req,
    input  logic [ADDR_WIDTH-1:0] rd_0_addr,
    output logic                  rd_0_ack,
    output logic [DATA_WIDTH-1:0] rd_0_data,
    output logic                  rd_0_vld,
    input  logic                  wr_0_req,
    input  logic [ADDR_WIDTH-1:0] wr_0_addr,
    input  logic [DATA_WIDTH-1:0] wr_0_data,
    output logic                  wr_0_ack
);

    localparam int  MEM_DEPTH   = 1 << MEM_ADDR_BITS;
    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

    // The contents start as zeros and reset never clears them, just like the
    // real part, which keeps its data across a logic reset.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

    logic                     last_grant;
    logic [RD_LATENCY-1:0]    vld_p;
    logic [DATA_WIDTH-1:0]    data_p [RD_LATENCY];
    logic [MEM_ADDR_BITS-1:0] rd_idx;
    logic [MEM_ADDR_BITS-1:0] wr_idx;

    assign rd_idx = rd_0_addr[MEM_ADDR_BITS-1:0];
    assign wr_idx = wr_0_addr[MEM_ADDR_BITS-1:0];

    // The aliased upper address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, rd_0_addr, wr_0_addr};

    // Arbitration. A tie goes to the side that was not granted last, so
    // requesters held high together alternate R, W, R, W.
    always_comb begin
        rd_0_ack = 1'b0;
        wr_0_ack = 1'b0;
        if (!reset) begin
            if (rd_0_req && wr_0_req) begin
                if (last_grant == GRANT_WRITE) begin
                    rd_0_ack = 1'b1;
                end else begin
                    wr_0_ack = 1'b1;
                end
            end else begin
                rd_0_ack = rd_0_req;
                wr_0_ack = wr_0_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GRANT_WRITE;
        end else if (rd_0_ack) begin
            last_grant <= GRANT_READ;
        end else if (wr_0_ack) begin
            last_grant <= GRANT_WRITE;
        end
    end

    // Write port
    always_ff @(posedge clk) begin
        if (wr_0_ack) begin
            mem[wr_idx] <= wr_0_data;
        end
    end

    // Read pipeline: stage 0 captures the word at the accept edge, and the
    // last stage drives the outputs. Only the valid bits are reset, which is
    // enough to discard any in-flight reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_0_ack;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_0_ack) begin
            data_p[0] <= mem[rd_idx];
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            data_p[i] <= data_p[i-1];
        end
    end

    // Output stage: the outputs are forced quiet while reset is high and
    // whenever the data is not valid.
    assign rd_0_vld  = vld_p[RD_LATENCY-1] & ~reset;
    assign rd_0_data = rd_0_vld ? data_p[RD_LATENCY-1] : '0;

endmodule

// File: tb/tb_fake_netfpga_sram.sv
module tb_fake_netfpga_sram;

    localparam int AW  = 19;
    localparam int DW  = 72;
    localparam int MAB = 10;
    localparam int RDL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_0_req;
    logic [AW-1:0] rd_0_addr;
    logic          rd_0_ack;
    logic [DW-1:0] rd_0_data;
    logic          rd_0_vld;
    logic          wr_0_req;
    logic [AW-1:0] wr_0_addr;
    logic [DW-1:0] wr_0_data;
    logic          wr_0_ack;

    fake_netfpga_sram #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_ADDR_BITS(MAB),
        .RD_LATENCY   (RDL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_0_req (rd_0_req),
        .rd_0_addr(rd_0_addr),
        .rd_0_ack (rd_0_ack),
        .rd_0_data(rd_0_data),
        .rd_0_vld (rd_0_vld),
        .wr_0_req (wr_0_req),
        .wr_0_addr(wr_0_addr),
        .wr_0_data(wr_0_data),
        .wr_0_ack (wr_0_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid beat is matched against the oldest expectation,
    // including the cycle it was due in. Idle cycles must show zero data.
    always @(negedge clk) begin
        if (rd_0_vld === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_vld: got data %h, required no valid beat (cycle %0d)", rd_0_data, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rd_data", rd_0_data, e.data);
                check("rd_cycle", DW'(cyc), DW'(e.due));
            end
        end else begin
            check("idle_data", rd_0_data, '0);
        end
    end

    // Present one cycle of stimulus, check the combinational acks, and queue
    // the expected read response. Accept edge = cyc+1, so the beat is due at
    // cyc + RDL.
    task automatic step(input logic rr, input logic [AW-1:0] ra,
                        input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic er, input logic ew, input logic [DW-1:0] ed,
                        input bit push);
        rd_0_req  = rr;
        rd_0_addr = ra;
        wr_0_req  = wr;
        wr_0_addr = wa;
        wr_0_data = wd;
        @(negedge clk);
        check("rd_ack", DW'(rd_0_ack), DW'(er));
        check("wr_ack", DW'(wr_0_ack), DW'(ew));
        if (er && push) q.push_back('{data: ed, due: cyc + RDL});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic reset_checks();
        check("rst_rd_ack", DW'(rd_0_ack), '0);
        check("rst_wr_ack", DW'(wr_0_ack), '0);
        check("rst_vld", DW'(rd_0_vld), '0);
        check("rst_data", rd_0_data, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish by 200000");
        $fatal(1);
    end

    initial begin
        // Reset with both requests already pending; the acks must stay low.
        reset     = 1'b1;
        rd_0_req  = 1'b1;
        rd_0_addr = 19'h00020;
        wr_0_req  = 1'b1;
        wr_0_addr = 19'h00020;
        wr_0_data = 72'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset_checks();
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        // Tie straight after reset: R, W, R, W. The second read sees the first write.
        step(1'b1, 19'h00020, 1'b1, 19'h00020, 72'hAA, 1'b1, 1'b0, 72'h0,  1'b1);
        step(1'b1, 19'h00020, 1'b1, 19'h00020, 72'hAA, 1'b0, 1'b1, 72'h0,  1'b1);
        step(1'b1, 19'h00020, 1'b1, 19'h00020, 72'hBB, 1'b1, 1'b0, 72'hAA, 1'b1);
        step(1'b1, 19'h00020, 1'b1, 19'h00020, 72'hBB, 1'b0, 1'b1, 72'h0,  1'b1);

        // Basic write, then read it back.
        step(1'b0, '0, 1'b1, 19'h00010, 72'h0A_1122334455667788, 1'b0, 1'b1, '0, 1'b0);
        step(1'b1, 19'h00010, 1'b0, '0, '0, 1'b1, 1'b0, 72'h0A_1122334455667788, 1'b1);

        // Never-written top address reads as zero.
        step(1'b1, 19'h7FFFF, 1'b0, '0, '0, 1'b1, 1'b0, 72'h0, 1'b1);

        // Preload 0..3 with 1..4, then four back-to-back reads.
        for (int i = 0; i < 4; i++)
            step(1'b0, '0, 1'b1, AW'(i), DW'(i + 1), 1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, AW'(i), 1'b0, '0, '0, 1'b1, 1'b0, DW'(i + 1), 1'b1);

        // Aliasing with 10 stored address bits: 0x405 maps onto 0x005.
        step(1'b0, '0, 1'b1, 19'h00005, 72'h55, 1'b0, 1'b1, '0, 1'b0);
        step(1'b1, 19'h00405, 1'b0, '0, '0, 1'b1, 1'b0, 72'h55, 1'b1);
        // Both aliases read back the later write to 0x405.
        step(1'b0, '0, 1'b1, 19'h00405, 72'h66, 1'b0, 1'b1, '0, 1'b0);
        step(1'b1, 19'h00005, 1'b0, '0, '0, 1'b1, 1'b0, 72'h66, 1'b1);

        idle();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle();
        check("drain_pending", DW'(q.size()), '0);

        // Two reads in flight, then reset: they must never appear.
        step(1'b1, 19'h00001, 1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 19'h00002, 1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        reset    = 1'b1;
        rd_0_req = 1'b1;
        wr_0_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset_checks();
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) idle();
        check("post_reset_pending", DW'(q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
